// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the secured-memory access arbiter.
// Holds the FSM state encoding, requester indices and fail-counter helpers.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT  = 3'd1,
    CHECK  = 3'd2,
    ACCESS = 3'd3,
    RESP   = 3'd4,
    FAULT  = 3'd5
  } arb_state_e;

  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_REG  = 1'b1;

  localparam int FAIL_CW = 3;

  function automatic logic [1:0] onehot2(input logic idx);
    if (idx == REQ_REG) return 2'b10;
    else return 2'b01;
  endfunction

  function automatic logic [FAIL_CW-1:0] sat_inc(input logic [FAIL_CW-1:0] v);
    if (v == {FAIL_CW{1'b1}}) return v;
    else return v + {{(FAIL_CW-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone eligible requester wins outright,
// a tie goes to the requester that was not granted last.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       rr_last,
  output logic       grant_valid,
  output logic       grant_idx
);

  // Combinational winner selection
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = REQ_HOST;
    case (eligible)
      2'b01: begin
        grant_valid = 1'b1;
        grant_idx   = REQ_HOST;
      end
      2'b10: begin
        grant_valid = 1'b1;
        grant_idx   = REQ_REG;
      end
      2'b11: begin
        grant_valid = 1'b1;
        grant_idx   = ~rr_last;
      end
      default: begin
        grant_valid = 1'b0;
        grant_idx   = REQ_HOST;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares the secured memory port between host and register-file spill/fill,
// checking each request's key and locking out requesters that keep failing.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW          = 10,
  parameter int DW          = 32,
  parameter int KW          = 16,
  parameter int LOCKOUT_MAX = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  input  logic [1:0]      req_we,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*DW-1:0] req_wdata,
  input  logic [2*KW-1:0] req_key,
  output logic [1:0]      req_ready,
  output logic [1:0]      rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic [1:0]      rsp_fault,
  output logic [1:0]      locked,
  input  logic [KW-1:0]   key_access,
  output logic            mem_wen,
  output logic            mem_ren,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam logic [FAIL_CW-1:0] LOCK_LIM = FAIL_CW'(LOCKOUT_MAX);

  arb_state_e state_r, state_s;

  logic                          gnt_r;
  logic                          we_r;
  logic [AW-1:0]                 addr_r;
  logic [DW-1:0]                 wdata_r;
  logic [KW-1:0]                 key_r;
  logic                          rr_last_r;
  logic [1:0][FAIL_CW-1:0]       fail_cnt_r;
  logic [1:0]                    locked_r;

  logic [1:0]                    req_ready_r;
  logic [1:0]                    rsp_valid_r;
  logic [1:0]                    rsp_fault_r;
  logic                          rd_bypass_r;
  logic [DW-1:0]                 rdata_r;
  logic                          mem_wen_r;
  logic                          mem_ren_r;
  logic [AW-1:0]                 mem_addr_r;
  logic [DW-1:0]                 mem_wdata_r;

  logic [1:0]                    eligible_s;
  logic                          grant_valid_s;
  logic                          grant_idx_s;
  logic                          key_ok_s;
  logic                          sel_we_s;
  logic [AW-1:0]                 sel_addr_s;
  logic [DW-1:0]                 sel_wdata_s;
  logic [KW-1:0]                 sel_key_s;

  assign eligible_s = req_valid & ~locked_r;
  assign key_ok_s   = (key_r == key_access);

  rr_arbiter2 u_rr (
    .eligible    (eligible_s),
    .rr_last     (rr_last_r),
    .grant_valid (grant_valid_s),
    .grant_idx   (grant_idx_s)
  );

  // Select the winning requester's transaction fields
  always_comb begin
    sel_we_s    = req_we[0];
    sel_addr_s  = req_addr[0 +: AW];
    sel_wdata_s = req_wdata[0 +: DW];
    sel_key_s   = req_key[0 +: KW];
    if (grant_idx_s == REQ_REG) begin
      sel_we_s    = req_we[1];
      sel_addr_s  = req_addr[AW +: AW];
      sel_wdata_s = req_wdata[DW +: DW];
      sel_key_s   = req_key[KW +: KW];
    end else begin
      sel_we_s    = req_we[0];
      sel_addr_s  = req_addr[0 +: AW];
      sel_wdata_s = req_wdata[0 +: DW];
      sel_key_s   = req_key[0 +: KW];
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_valid_s) state_s = GRANT;
        else state_s = IDLE;
      end
      GRANT: state_s = CHECK;
      CHECK: begin
        if (key_ok_s) state_s = ACCESS;
        else state_s = FAULT;
      end
      ACCESS:  state_s = RESP;
      RESP:    state_s = IDLE;
      FAULT:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else state_r <= state_s;
  end

  // Latch the granted transaction and remember who won for the next tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_r     <= REQ_HOST;
      we_r      <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      key_r     <= '0;
      rr_last_r <= REQ_REG;
    end else if (state_r == IDLE && grant_valid_s) begin
      gnt_r     <= grant_idx_s;
      we_r      <= sel_we_s;
      addr_r    <= sel_addr_s;
      wdata_r   <= sel_wdata_s;
      key_r     <= sel_key_s;
      rr_last_r <= grant_idx_s;
    end
  end

  // Consecutive key-failure counters and sticky lockout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_cnt_r <= '0;
      locked_r   <= 2'b00;
    end else if (state_r == CHECK && key_ok_s) begin
      fail_cnt_r[gnt_r] <= '0;
    end else if (state_r == FAULT) begin
      fail_cnt_r[gnt_r] <= sat_inc(fail_cnt_r[gnt_r]);
      if (sat_inc(fail_cnt_r[gnt_r]) >= LOCK_LIM) locked_r[gnt_r] <= 1'b1;
    end
  end

  // Registered strobes: each appears the cycle after the state that owns it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r <= 2'b00;
      mem_wen_r   <= 1'b0;
      mem_ren_r   <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      rsp_valid_r <= 2'b00;
      rd_bypass_r <= 1'b0;
      rsp_fault_r <= 2'b00;
      rdata_r     <= '0;
    end else begin
      req_ready_r <= (state_r == IDLE && grant_valid_s) ? onehot2(grant_idx_s) : 2'b00;
      mem_wen_r   <= (state_r == ACCESS) && we_r;
      mem_ren_r   <= (state_r == ACCESS) && !we_r;
      mem_addr_r  <= (state_r == ACCESS) ? addr_r : '0;
      mem_wdata_r <= (state_r == ACCESS) ? wdata_r : '0;
      rsp_valid_r <= (state_r == RESP) ? onehot2(gnt_r) : 2'b00;
      rd_bypass_r <= (state_r == RESP) && !we_r;
      rsp_fault_r <= (state_r == FAULT) ? onehot2(gnt_r) : 2'b00;
      if (rd_bypass_r) rdata_r <= mem_rdata;
    end
  end

  // Read data arrives alongside rsp_valid, so it is passed through that cycle and held afterwards
  assign rsp_rdata = rd_bypass_r ? mem_rdata : rdata_r;
  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_fault = rsp_fault_r;
  assign locked    = locked_r;
  assign mem_wen   = mem_wen_r;
  assign mem_ren   = mem_ren_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench: directed scenarios plus random rounds against a transaction-level model.
module tb_mem_access_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int KW = 16;
  localparam int LOCKOUT_MAX = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid, req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [2*KW-1:0] req_key;
  logic [1:0]      req_ready, rsp_valid, rsp_fault, locked;
  logic [DW-1:0]   rsp_rdata;
  logic [KW-1:0]   key_access;
  logic            mem_wen, mem_ren;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  mem_access_arbiter #(.AW(AW), .DW(DW), .KW(KW), .LOCKOUT_MAX(LOCKOUT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_key(req_key), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .locked(locked), .key_access(key_access),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // synchronous-read memory behind the port
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] <= mem_wdata;
    if (mem_ren) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    int            cyc;
    int            idx;
    logic [DW-1:0] data;
    logic          we;
    logic [AW-1:0] addr;
  } ev_t;

  ev_t rdy_q[$], rsp_q[$], flt_q[$], mem_q[$];
  int  cyc = 0;
  int  both_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // event logger, sampled mid-cycle
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (req_ready[i]) rdy_q.push_back('{cyc: cyc, idx: i, data: '0, we: 1'b0, addr: '0});
      if (rsp_valid[i]) rsp_q.push_back('{cyc: cyc, idx: i, data: rsp_rdata, we: 1'b0, addr: '0});
      if (rsp_fault[i]) flt_q.push_back('{cyc: cyc, idx: i, data: '0, we: 1'b0, addr: '0});
    end
    if (mem_wen || mem_ren)
      mem_q.push_back('{cyc: cyc, idx: 0, data: mem_wdata, we: mem_wen, addr: mem_addr});
    if (mem_wen && mem_ren) both_en = both_en + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic          m_rr;
  logic [2:0]    m_cnt [2];
  logic [1:0]    m_locked;
  logic [DW-1:0] m_last;
  logic [DW-1:0] m_mem [0:7];

  // staging for the next round
  logic          st_we   [2];
  logic [AW-1:0] st_addr [2];
  logic [DW-1:0] st_data [2];
  logic [KW-1:0] st_key  [2];
  logic [KW-1:0] st_kacc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 1'b1;
    m_cnt[0] = 3'd0;
    m_cnt[1] = 3'd0;
    m_locked = 2'b00;
    m_last = '0;
  endtask

  task automatic stage(input int i, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [KW-1:0] k);
    st_we[i] = we; st_addr[i] = a; st_data[i] = d; st_key[i] = k;
  endtask

  // drive one round of requests, then compare logged events with the model
  task automatic run_round(input logic [1:0] act);
    int s, r0, p0, f0, q0, t, g;
    logic [1:0] elig;
    int order[$];
    ev_t e_rsp[$], e_flt[$], e_mem[$];
    key_access = st_kacc;
    @(posedge clk); #1;
    s = cyc; r0 = rdy_q.size(); p0 = rsp_q.size(); f0 = flt_q.size(); q0 = mem_q.size();
    for (int i = 0; i < 2; i++) begin
      req_we[i] = st_we[i];
      req_addr[i*AW +: AW] = st_addr[i];
      req_wdata[i*DW +: DW] = st_data[i];
      req_key[i*KW +: KW] = st_key[i];
    end
    req_valid = act;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      req_valid = req_valid & ~req_ready;
    end
    req_valid = 2'b00;

    elig = act & ~m_locked;
    if (elig == 2'b11) begin
      order.push_back(m_rr ? 0 : 1);
      order.push_back(m_rr ? 1 : 0);
    end else if (elig[0]) order.push_back(0);
    else if (elig[1]) order.push_back(1);
    else order.delete();

    t = s + 1;
    chk("ready_count", 64'(rdy_q.size() - r0), 64'(order.size()));
    for (int k = 0; k < order.size(); k++) begin
      g = order[k];
      if (r0 + k < rdy_q.size()) begin
        chk("ready_idx", 64'(rdy_q[r0+k].idx), 64'(g));
        chk("ready_cycle", 64'(rdy_q[r0+k].cyc - s), 64'(t - s));
      end
      if (st_key[g] == st_kacc) begin
        e_mem.push_back('{cyc: t + 3, idx: 0, data: st_data[g], we: st_we[g], addr: st_addr[g]});
        if (st_we[g]) begin
          e_rsp.push_back('{cyc: t + 4, idx: g, data: m_last, we: 1'b1, addr: '0});
          m_mem[st_addr[g][2:0]] = st_data[g];
        end else begin
          m_last = m_mem[st_addr[g][2:0]];
          e_rsp.push_back('{cyc: t + 4, idx: g, data: m_last, we: 1'b0, addr: '0});
        end
        m_cnt[g] = 3'd0;
        t = t + 5;
      end else begin
        e_flt.push_back('{cyc: t + 3, idx: g, data: '0, we: 1'b0, addr: '0});
        if (m_cnt[g] != 3'd7) m_cnt[g] = m_cnt[g] + 3'd1;
        if (int'(m_cnt[g]) >= LOCKOUT_MAX) m_locked[g] = 1'b1;
        t = t + 4;
      end
      m_rr = g[0];
    end

    chk("rsp_count", 64'(rsp_q.size() - p0), 64'(e_rsp.size()));
    for (int k = 0; k < e_rsp.size() && p0 + k < rsp_q.size(); k++) begin
      chk("rsp_idx", 64'(rsp_q[p0+k].idx), 64'(e_rsp[k].idx));
      chk("rsp_cycle", 64'(rsp_q[p0+k].cyc - s), 64'(e_rsp[k].cyc - s));
      chk("rsp_rdata", 64'(rsp_q[p0+k].data), 64'(e_rsp[k].data));
    end
    chk("fault_count", 64'(flt_q.size() - f0), 64'(e_flt.size()));
    for (int k = 0; k < e_flt.size() && f0 + k < flt_q.size(); k++) begin
      chk("fault_idx", 64'(flt_q[f0+k].idx), 64'(e_flt[k].idx));
      chk("fault_cycle", 64'(flt_q[f0+k].cyc - s), 64'(e_flt[k].cyc - s));
    end
    chk("mem_count", 64'(mem_q.size() - q0), 64'(e_mem.size()));
    for (int k = 0; k < e_mem.size() && q0 + k < mem_q.size(); k++) begin
      chk("mem_cycle", 64'(mem_q[q0+k].cyc - s), 64'(e_mem[k].cyc - s));
      chk("mem_we", 64'(mem_q[q0+k].we), 64'(e_mem[k].we));
      chk("mem_addr", 64'(mem_q[q0+k].addr), 64'(e_mem[k].addr));
      if (e_mem[k].we) chk("mem_wdata", 64'(mem_q[q0+k].data), 64'(e_mem[k].data));
    end
    chk("locked", 64'(locked), 64'(m_locked));
    chk("both_enables", 64'(both_en), 64'd0);
  endtask

  initial begin
    logic [1:0] act;
    int n, p0, f0;
    rst_n = 1'b0;
    req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0; req_key = '0;
    key_access = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_strobes", 64'({req_ready, rsp_valid, rsp_fault, locked, mem_wen, mem_ren}), 64'd0);
    chk("reset_mem_addr", 64'(mem_addr), 64'd0);
    chk("reset_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
    rst_n = 1'b1;

    // both requesters from reset: host first, then register file, alternating
    st_kacc = 16'h5A5A;
    stage(0, 1'b1, 10'd0, 32'h0000_1111, 16'h5A5A);
    stage(1, 1'b1, 10'd1, 32'h0000_2222, 16'h5A5A);
    run_round(2'b11);
    run_round(2'b11);

    // fill the shadowed region, 0x005 holding the read-back pattern
    for (int a = 0; a < 8; a++) begin
      stage(a % 2, 1'b1, AW'(a), (a == 5) ? 32'hDEADBEEF : $urandom, 16'h5A5A);
      run_round((a % 2) ? 2'b10 : 2'b01);
    end

    // host read of 0x005
    stage(0, 1'b0, 10'h005, 32'h0, 16'h5A5A);
    run_round(2'b01);
    chk("host_read_deadbeef", 64'(rsp_q[rsp_q.size()-1].data), 64'h0000_0000_DEADBEEF);

    // register-file write with a wrong key
    st_kacc = 16'hBEEF;
    stage(1, 1'b1, 10'd2, 32'hCAFE_0000, 16'h1234);
    run_round(2'b10);

    // success clears the failure streak: S F F S F F leaves requester 1 unlocked
    for (int k = 0; k < 6; k++) begin
      stage(1, 1'b1, 10'd6, $urandom, (k == 0 || k == 3) ? 16'hBEEF : 16'h0BAD);
      run_round(2'b10);
    end
    chk("reg_not_locked", 64'(locked[1]), 64'd0);

    // random rounds; a third consecutive miss is avoided so nobody locks here
    for (n = 0; n < 30; n++) begin
      act = 2'($urandom_range(3, 0));
      st_kacc = KW'($urandom);
      for (int i = 0; i < 2; i++) begin
        stage(i, 1'($urandom_range(1, 0)), AW'($urandom_range(7, 0)), $urandom, st_kacc);
        if ($urandom_range(99, 0) < 30 && int'(m_cnt[i]) < LOCKOUT_MAX - 1)
          st_key[i] = st_kacc ^ KW'($urandom_range(65535, 1));
      end
      run_round(act);
    end

    // three host misses lock the host; register file still served
    st_kacc = 16'h0F0F;
    for (int k = 0; k < 3; k++) begin
      stage(0, 1'b0, 10'd3, 32'h0, 16'hF0F0);
      run_round(2'b01);
    end
    chk("host_locked", 64'(locked[0]), 64'd1);
    stage(0, 1'b1, 10'd4, 32'h1234_5678, 16'h0F0F);
    stage(1, 1'b0, 10'd5, 32'h0, 16'h0F0F);
    run_round(2'b11);

    // reset in the middle of a memory access
    key_access = 16'h0F0F;
    @(posedge clk); #1;
    req_we[1] = 1'b0; req_addr[AW +: AW] = 10'd3; req_key[KW +: KW] = 16'h0F0F;
    req_valid = 2'b10;
    n = 0;
    while (!(mem_ren || mem_wen) && n < 12) begin
      @(posedge clk); #1;
      req_valid = req_valid & ~req_ready;
      n++;
    end
    chk("abort_access_seen", 64'(mem_ren), 64'd1);
    p0 = rsp_q.size(); f0 = flt_q.size();
    rst_n = 1'b0;
    #1;
    chk("abort_enables", 64'({mem_wen, mem_ren}), 64'd0);
    chk("abort_locked", 64'(locked), 64'd0);
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_rsp", 64'(rsp_q.size() - p0), 64'd0);
    chk("abort_no_fault", 64'(flt_q.size() - f0), 64'd0);

    // after reset the host wins the first tie again
    st_kacc = 16'h7777;
    stage(0, 1'b1, 10'd7, $urandom, 16'h7777);
    stage(1, 1'b0, 10'd5, 32'h0, 16'h7777);
    run_round(2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
